reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single register-file write port between two requesters.
  - The in-order pipeline writeback: fixed priority, never back-pressured.
  - The multi-cycle mul/div unit: valid/ready handshake, buffered in a small FIFO.
- Holds a per-register scoreboard of destinations pending in mul/div, and raises a stall to ID on RAW or WAW hazards.
- Sits between the WB stage / mul-div unit and the register file write inputs (we, waddr, wd).

Parameters:
- DATA_W, 32, data width of register contents.
- ADDR_W, 5, register address width (32 registers).
- FIFO_DEPTH, 2, mul/div writeback buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- p_we  in  1  pipeline writeback enable.
- p_waddr  in  ADDR_W  pipeline destination register.
- p_wd  in  DATA_W  pipeline writeback data.
- m_valid  in  1  mul/div result valid.
- m_waddr  in  ADDR_W  mul/div destination register.
- m_wd  in  DATA_W  mul/div result data.
- m_ready  out  1  FIFO can accept a result.
- issue_valid  in  1  mul/div instruction issued this cycle.
- issue_rd  in  ADDR_W  destination of the issued mul/div.
- rs1_addr  in  ADDR_W  ID-stage source 1.
- rs2_addr  in  ADDR_W  ID-stage source 2.
- rd_addr  in  ADDR_W  ID-stage destination (WAW check).
- hazard_stall  out  1  ID must stall.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wd  out  DATA_W  register file write data.

Behaviour:
- Reset (rst low, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wd=0.
  - FIFO emptied; busy vector cleared.
  - m_ready forced 0 while rst is low.
  - Assertion mid-operation discards all buffered results and pending busy bits.
- rf_* outputs are registered, one-cycle latency from the selection decision.
- Selection each cycle:
  - If p_we=1 and p_waddr!=0: the pipeline write wins. At the next edge rf_we=1 with p_waddr/p_wd.
  - Otherwise, if the FIFO is non-empty: pop the head. At the next edge rf_we=1 with the head's address and data.
  - Otherwise rf_we=0. rf_waddr/rf_wd hold their previous values.
- p_we with p_waddr=0 is ignored (x0 is never written).
- m_ready = !full, computed from registered state only. No combinational path from m_valid.
  - Accept on m_valid & m_ready at the edge.
  - An accepted entry with m_waddr=0 is dropped: not pushed, handshake still completes.
- Push and pop in the same cycle are allowed when not full; FIFO occupancy stays unchanged.
  - When full, m_ready=0, even if a pop occurs that cycle.
  - An accepted entry writes no earlier than 2 edges after acceptance (push edge, then selection cycle, then rf edge).
- FIFO order is strict: first in, first out. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard, busy[31:0], with busy[0] hard-wired to 0:
  - Set at the edge when issue_valid=1 and issue_rd!=0.
  - Cleared at the edge where that register's FIFO entry is popped, i.e. the same edge rf_we rises for it.
  - If set and clear hit the same register at the same edge, set wins (the newer issue is outstanding).
- hazard_stall = busy[rs1_addr] | busy[rs2_addr] | busy[rd_addr]. Purely combinational from registered busy.
- The pipeline is never stalled by FIFO starvation. A continuous p_we stream can delay mul/div writes indefinitely; this is accepted by design because hazard_stall bounds it.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W constants.
  - REG_ZERO = 5'd0.
  - A wb_entry struct/packed pair {addr, data} used by the FIFO and the selection mux.
- One natural sub-module: wb_fifo. Parameterised DEPTH x (ADDR_W+DATA_W) synchronous FIFO with full/empty flags and the same async active-low reset.
- Scoreboard and selection logic stay in the top.

Test Plan:
- Priority: p_we=1 x5=0x11 and m_valid x6=0x22 in the same cycle.
  - Next edge: rf_we=1, rf_waddr=5, rf_wd=0x11.
  - Following edge: rf_waddr=6, rf_wd=0x22.
- Scoreboard:
  - issue_valid x7, then hold rs1_addr=7: hazard_stall=1 from the edge after issue.
  - m_valid x7=0xABCD: hazard_stall stays 1 until the edge where rf_we writes x7, then 0.
- Full:
  - p_we every cycle for 5 cycles while m_valid pushes x8, x9, x10: m_ready drops after 2 accepts.
  - x10 is held until a pop frees space; drain order is x8, x9, x10.
- x0 handling:
  - p_we with x0: rf_we stays 0.
  - issue_rd=0 then rs1=0: hazard_stall=0.
  - m_valid x0: accepted, FIFO stays empty.
- Same-edge set/clear: re-issue x9 on the edge its previous result pops; busy[9] remains 1 and hazard_stall stays 1 for rs2=9.
- Reset mid-op:
  - Drop rst low with the FIFO full and busy[12]=1: rf_we=0 and m_ready=0 immediately (async).
  - After release: m_ready=1, hazard_stall=0, no stale write appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, the x0 constant and the writeback entry type used by the
// register-file write arbiter and its mul/div result buffer.
package cpu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Which requester owns the write port in the current cycle.
   typedef enum logic [1:0] {
      WB_NONE,
      WB_PIPE,
      WB_FIFO
   } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering mul/div writeback entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 37
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // Storage carries no reset; the flags alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between the pipeline writeback and the
// mul/div unit, and tracks mul/div destinations still in flight for ID stalls.
module reg_write_arbiter #(
   parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W     = cpu_pkg::ADDR_W,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_waddr,
   input  logic [DATA_W-1:0] p_wd,
   input  logic              m_valid,
   input  logic [ADDR_W-1:0] m_waddr,
   input  logic [DATA_W-1:0] m_wd,
   output logic              m_ready,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              hazard_stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wd
);

   import cpu_pkg::*;

   localparam int unsigned NREG = 1 << ADDR_W;

   wb_entry_t       m_entry;
   wb_entry_t       head;
   wb_src_t         src;
   logic            fifo_full;
   logic            fifo_empty;
   logic            accept;
   logic            push;
   logic            pop;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;

   // Ready depends only on registered occupancy (and reset), never on m_valid.
   assign m_ready = rst & ~fifo_full;
   assign accept  = m_valid & m_ready;
   assign push    = accept & (m_waddr != REG_ZERO);
   assign m_entry = '{addr: m_waddr, data: m_wd};

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(wb_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (m_entry),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      src = WB_NONE;
      if (p_we && (p_waddr != REG_ZERO)) src = WB_PIPE;
      else if (!fifo_empty)              src = WB_FIFO;
   end

   assign pop = (src == WB_FIFO);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wd    <= '0;
      end else begin
         case (src)
            WB_PIPE: begin
               rf_we    <= 1'b1;
               rf_waddr <= p_waddr;
               rf_wd    <= p_wd;
            end
            WB_FIFO: begin
               rf_we    <= 1'b1;
               rf_waddr <= head.addr;
               rf_wd    <= head.data;
            end
            default: rf_we <= 1'b0;
         endcase
      end
   end

   // Set is applied after clear so a re-issue on the popping edge stays busy.
   always_comb begin
      busy_next = busy;
      if (pop) busy_next[head.addr] = 1'b0;
      if (issue_valid && (issue_rd != REG_ZERO)) busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_next;
   end

   assign hazard_stall = busy[rs1_addr] | busy[rs2_addr] | busy[rd_addr];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reg_write_arbiter;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        p_we = 1'b0;
   logic [4:0]  p_waddr = '0;
   logic [31:0] p_wd = '0;
   logic        m_valid = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wd = '0;
   logic        m_ready;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic [4:0]  rd_addr = '0;
   logic        hazard_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wd;

   int unsigned passed = 0;
   int unsigned total  = 0;

   reg_write_arbiter #(
      .DATA_W     (32),
      .ADDR_W     (5),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .p_we         (p_we),
      .p_waddr      (p_waddr),
      .p_wd         (p_wd),
      .m_valid      (m_valid),
      .m_waddr      (m_waddr),
      .m_wd         (m_wd),
      .m_ready      (m_ready),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rd_addr      (rd_addr),
      .hazard_stall (hazard_stall),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wd        (rf_wd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: queue of pending results, bit per busy register.
   logic [36:0] q[$];
   logic [31:0] busy_m = '0;
   logic        exp_we = 1'b0;
   logic [4:0]  exp_waddr = '0;
   logic [31:0] exp_wd = '0;

   always @(posedge clk or negedge rst) begin
      logic        acc;
      logic        pipe;
      logic [36:0] hd;
      if (!rst) begin
         q.delete();
         busy_m    = '0;
         exp_we    = 1'b0;
         exp_waddr = '0;
         exp_wd    = '0;
      end else begin
         acc  = m_valid && (q.size() < DEPTH);
         pipe = p_we && (p_waddr != 0);
         if (pipe) begin
            exp_we = 1'b1; exp_waddr = p_waddr; exp_wd = p_wd;
         end else if (q.size() != 0) begin
            hd = q.pop_front();
            exp_we = 1'b1; exp_waddr = hd[36:32]; exp_wd = hd[31:0];
            busy_m[hd[36:32]] = 1'b0;
         end else begin
            exp_we = 1'b0;
         end
         if (acc && m_waddr != 0) q.push_back({m_waddr, m_wd});
         if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("rf_we", rf_we, exp_we);
      chk("rf_waddr", rf_waddr, exp_waddr);
      chk("rf_wd", rf_wd, exp_wd);
      chk("m_ready", m_ready, rst && (q.size() < DEPTH));
      chk("hazard_stall", hazard_stall,
          busy_m[rs1_addr] | busy_m[rs2_addr] | busy_m[rd_addr]);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      p_we = 1'b0; p_waddr = '0; p_wd = '0;
      m_valid = 1'b0; m_waddr = '0; m_wd = '0;
      issue_valid = 1'b0; issue_rd = '0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
   endtask

   initial begin
      logic [4:0] items[3];
      logic [4:0] drained[$];
      int         idx;
      int         cyc;
      int         acc_cyc;
      logic       accepted;

      // Reset state
      tick(); tick();
      #1;
      chk("reset_rf_we", rf_we, 1'b0);
      chk("reset_rf_waddr", rf_waddr, 5'd0);
      chk("reset_m_ready", m_ready, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      chk("release_m_ready", m_ready, 1'b1);
      tick();

      // Priority: pipeline beats mul/div in the same cycle
      p_we = 1'b1; p_waddr = 5'd5; p_wd = 32'h11;
      m_valid = 1'b1; m_waddr = 5'd6; m_wd = 32'h22;
      tick();
      idle_inputs();
      #1;
      chk("prio_we", rf_we, 1'b1);
      chk("prio_addr", rf_waddr, 5'd5);
      chk("prio_wd", rf_wd, 32'h11);
      tick(); #1;
      chk("prio2_addr", rf_waddr, 5'd6);
      chk("prio2_wd", rf_wd, 32'h22);
      tick(); #1;
      chk("prio_idle_we", rf_we, 1'b0);

      // Scoreboard set and clear on writeback
      issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
      #1;
      chk("sb_pre_stall", hazard_stall, 1'b0);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("sb_stall", hazard_stall, 1'b1);
      m_valid = 1'b1; m_waddr = 5'd7; m_wd = 32'hABCD;
      tick();
      m_valid = 1'b0;
      #1;
      chk("sb_stall_pushed", hazard_stall, 1'b1);
      tick(); #1;
      chk("sb_wb_addr", rf_waddr, 5'd7);
      chk("sb_wb_data", rf_wd, 32'hABCD);
      chk("sb_cleared", hazard_stall, 1'b0);
      idle_inputs();

      // x0 handling
      p_we = 1'b1; p_waddr = 5'd0; p_wd = 32'hDEAD;
      tick();
      p_we = 1'b0;
      #1;
      chk("x0_pipe_we", rf_we, 1'b0);
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      issue_valid = 1'b0; rs1_addr = 5'd0;
      #1;
      chk("x0_issue_stall", hazard_stall, 1'b0);
      m_valid = 1'b1; m_waddr = 5'd0; m_wd = 32'hBEEF;
      #1;
      chk("x0_m_ready", m_ready, 1'b1);
      tick();
      m_valid = 1'b0;
      tick(); #1;
      chk("x0_m_dropped", rf_we, 1'b0);
      idle_inputs();

      // FIFO full: pipeline holds the port while three results arrive
      items[0] = 5'd8; items[1] = 5'd9; items[2] = 5'd10;
      idx = 0; cyc = 0; acc_cyc = -1;
      while (idx < 3 && cyc < 40) begin
         p_we = (cyc < 5); p_waddr = 5'(cyc + 1); p_wd = 32'(cyc);
         m_valid = 1'b1; m_waddr = items[idx]; m_wd = 32'h100 + 32'(items[idx]);
         if (cyc == 2) chk("full_ready_low", m_ready, 1'b0);
         if (cyc == 5) chk("full_ready_low_on_pop", m_ready, 1'b0);
         accepted = m_ready;
         tick();
         if (accepted) begin
            if (idx == 2) acc_cyc = cyc;
            idx++;
         end
         #1;
         if (rf_we && rf_waddr >= 5'd8) drained.push_back(rf_waddr);
         cyc++;
      end
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         if (rf_we && rf_waddr >= 5'd8) drained.push_back(rf_waddr);
      end
      chk("full_x10_accept_cycle", 64'(acc_cyc), 64'd6);
      chk("drain_count", 64'(drained.size()), 64'd3);
      if (drained.size() == 3) begin
         chk("drain0", drained[0], 5'd8);
         chk("drain1", drained[1], 5'd9);
         chk("drain2", drained[2], 5'd10);
      end

      // Same-edge set/clear on x9
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0; rs2_addr = 5'd9;
      m_valid = 1'b1; m_waddr = 5'd9; m_wd = 32'h99;
      tick();
      m_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0;
      #1;
      chk("setclr_addr", rf_waddr, 5'd9);
      chk("setclr_stall", hazard_stall, 1'b1);
      m_valid = 1'b1; m_waddr = 5'd9; m_wd = 32'h98;
      tick();
      m_valid = 1'b0;
      tick(); #1;
      chk("setclr_wd2", rf_wd, 32'h98);
      chk("setclr_stall_clear", hazard_stall, 1'b0);
      idle_inputs();

      // Reset mid-operation with a full FIFO and x12 busy
      issue_valid = 1'b1; issue_rd = 5'd12;
      p_we = 1'b1; p_waddr = 5'd1; p_wd = 32'h1;
      m_valid = 1'b1; m_waddr = 5'd12; m_wd = 32'hC12;
      tick();
      issue_valid = 1'b0; rs1_addr = 5'd12;
      m_waddr = 5'd13; m_wd = 32'hC13;
      tick();
      m_valid = 1'b0;
      #1;
      chk("rstmid_full", m_ready, 1'b0);
      chk("rstmid_busy", hazard_stall, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      chk("rstmid_we", rf_we, 1'b0);
      chk("rstmid_ready", m_ready, 1'b0);
      tick(); tick();
      p_we = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstrel_ready", m_ready, 1'b1);
      chk("rstrel_stall", hazard_stall, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("rstrel_no_stale", rf_we, 1'b0);
      end
      idle_inputs();

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (i == 1000) rst = 1'b0;
         else rst = 1'b1;
         p_we        = ($urandom_range(0, 99) < 50);
         p_waddr     = 5'($urandom_range(0, 7));
         p_wd        = $urandom;
         m_valid     = ($urandom_range(0, 99) < 60);
         m_waddr     = 5'($urandom_range(0, 7));
         m_wd        = $urandom;
         issue_valid = ($urandom_range(0, 99) < 25);
         issue_rd    = 5'($urandom_range(0, 7));
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         rd_addr     = 5'($urandom_range(0, 7));
      end
      tick();
      idle_inputs();
      tick();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
